// File: rtl/ub_stream_sequencer.sv
// ub_stream_sequencer: initiator for the buffer/array streaming interface.
// Latches one job descriptor and then runs the job through these phases:
// clear the accumulators, stream the input and weight row addresses,
// flush the array skew, drain with PPU capture, do one PPU writeback, done.
//
// Optional feature: defining SEQ_PERF_CNT_EN adds the perf_cycles output,
// which reports the busy-cycle count of the most recent completed job.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, abort                  job request / cancel
//   k_len, in_base, wt_base,      job descriptor (latched on accept)
//   stride, out_addr, mode_in
//   busy, done, err               status (done/err are one-cycle pulses)
//   sa_input_*/sa_weight_*        row-address streams with first/last markers
//   precision_mode                latched precision for the running job
//   compute_enable, acc_clear,    array control
//   drain_enable
//   ppu_capture_en, ppu_cycle_idx PPU capture strobe and drain row index
//   ub_wr_en, ub_wr_addr          unified-buffer writeback
//   perf_cycles                   (SEQ_PERF_CNT_EN only) busy cycles of last job
module ub_stream_sequencer #(
  parameter int unsigned ARRAY_SIZE   = 4,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned FLUSH_CYCLES = 2*ARRAY_SIZE+1,
  parameter int unsigned K_WIDTH      = 8,
  parameter type precision_mode_t     = logic [1:0],
  localparam int unsigned IDX_W       = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] wt_base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [ADDR_WIDTH-1:0] out_addr,
  input  precision_mode_t       mode_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] sa_input_addr,
  output logic [ADDR_WIDTH-1:0] sa_weight_addr,
  output logic                  sa_input_first,
  output logic                  sa_weight_first,
  output logic                  sa_input_last,
  output logic                  sa_weight_last,
  output precision_mode_t       precision_mode,
  output logic                  compute_enable,
  output logic                  acc_clear,
  output logic                  drain_enable,
  output logic                  ppu_capture_en,
  output logic [IDX_W-1:0]      ppu_cycle_idx,
  output logic                  ub_wr_en,
  output logic [ADDR_WIDTH-1:0] ub_wr_addr
`ifdef SEQ_PERF_CNT_EN
  ,output logic [31:0]          perf_cycles
`endif
);

  // Phase counter must cover k_len, FLUSH_CYCLES and ARRAY_SIZE.
  localparam int unsigned FL_W   = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned AR_W   = $clog2(ARRAY_SIZE + 1);
  localparam int unsigned CNT_W0 = (K_WIDTH > FL_W) ? K_WIDTH : FL_W;
  localparam int unsigned CNT_W  = (CNT_W0 > AR_W) ? CNT_W0 : AR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t                state, next_state;
  logic [CNT_W-1:0]      cnt, cnt_d, k_last;
  logic                  accept;

  logic [K_WIDTH-1:0]    k_q;
  logic [ADDR_WIDTH-1:0] in_base_q, wt_base_q, stride_q, out_q;

  logic                  busy_d, done_d, err_d, acc_clear_d, compute_d;
  logic                  drain_d, capture_d, wr_en_d, first_d, last_d;
  logic [IDX_W-1:0]      idx_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d, in_addr_d, wt_addr_d;

  assign accept = (state == S_IDLE) && start && !abort && (k_len != '0);
  assign k_last = CNT_W'(k_q) - CNT_W'(1);

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
    end
  end

  // Next state; abort overrides every busy phase.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept) next_state = S_CLEAR;
      S_CLEAR:  next_state = S_STREAM;
      S_STREAM: if (cnt == k_last) next_state = S_FLUSH;
      S_FLUSH:  if (cnt == CNT_W'(FLUSH_CYCLES - 1)) next_state = S_DRAIN;
      S_DRAIN:  if (cnt == CNT_W'(ARRAY_SIZE - 1)) next_state = S_WRITE;
      S_WRITE:  next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) next_state = S_IDLE;
    // Counter restarts at 0 in each phase.
    cnt_d = ((next_state != state) || (state == S_IDLE)) ? '0 : cnt + CNT_W'(1);
  end

  // Output decode of the upcoming phase, so registered outputs line up with it.
  always_comb begin
    busy_d      = (next_state != S_IDLE);
    done_d      = (next_state == S_DONE);
    err_d       = (state == S_IDLE) && start && !abort && (k_len == '0);
    acc_clear_d = (next_state == S_CLEAR);
    compute_d   = (next_state == S_STREAM) || (next_state == S_FLUSH);
    drain_d     = (next_state == S_DRAIN) || (next_state == S_WRITE);
    capture_d   = (next_state == S_DRAIN);
    idx_d       = (next_state == S_DRAIN) ? cnt_d[IDX_W-1:0] : '0;
    wr_en_d     = (next_state == S_WRITE);
    wr_addr_d   = (next_state == S_WRITE) ? out_q : '0;
    in_addr_d   = sa_input_addr;
    wt_addr_d   = sa_weight_addr;
    first_d     = 1'b0;
    last_d      = 1'b0;
    if (next_state == S_STREAM) begin
      // Incremental address walk; wraps modulo 2^ADDR_WIDTH.
      if (state == S_STREAM) begin
        in_addr_d = sa_input_addr + stride_q;
        wt_addr_d = sa_weight_addr + stride_q;
      end else begin
        in_addr_d = in_base_q;
        wt_addr_d = wt_base_q;
      end
      first_d = (cnt_d == '0);
      last_d  = (cnt_d == k_last);
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      acc_clear       <= 1'b0;
      compute_enable  <= 1'b0;
      drain_enable    <= 1'b0;
      ppu_capture_en  <= 1'b0;
      ppu_cycle_idx   <= '0;
      ub_wr_en        <= 1'b0;
      ub_wr_addr      <= '0;
      sa_input_addr   <= '0;
      sa_weight_addr  <= '0;
      sa_input_first  <= 1'b0;
      sa_weight_first <= 1'b0;
      sa_input_last   <= 1'b0;
      sa_weight_last  <= 1'b0;
      precision_mode  <= precision_mode_t'('0);
    end else begin
      busy            <= busy_d;
      done            <= done_d;
      err             <= err_d;
      acc_clear       <= acc_clear_d;
      compute_enable  <= compute_d;
      drain_enable    <= drain_d;
      ppu_capture_en  <= capture_d;
      ppu_cycle_idx   <= idx_d;
      ub_wr_en        <= wr_en_d;
      ub_wr_addr      <= wr_addr_d;
      sa_input_addr   <= in_addr_d;
      sa_weight_addr  <= wt_addr_d;
      sa_input_first  <= first_d;
      sa_weight_first <= first_d;
      sa_input_last   <= last_d;
      sa_weight_last  <= last_d;
      if (accept) precision_mode <= mode_in;
    end
  end

  // Job descriptor latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q       <= '0;
      in_base_q <= '0;
      wt_base_q <= '0;
      stride_q  <= '0;
      out_q     <= '0;
    end else if (accept) begin
      k_q       <= k_len;
      in_base_q <= in_base;
      wt_base_q <= wt_base;
      stride_q  <= stride;
      out_q     <= out_addr;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // perf_cnt holds the index of the current busy cycle (1 in CLEAR), so the
  // value published on entry to DONE equals the job's total busy cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept) perf_cnt <= 32'd1;
      else if (next_state != S_IDLE) perf_cnt <= perf_cnt + 32'd1;
      if ((state != S_DONE) && (next_state == S_DONE)) perf_cycles <= perf_cnt + 32'd1;
    end
  end
`else
  // Performance counter not built.
`endif

endmodule

// File: tb/tb_ub_stream_sequencer.sv
module tb_ub_stream_sequencer;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned KW = 8;
  localparam int unsigned F  = 2*N+1;
  localparam int unsigned IW = $clog2(N);

  logic          clk, rst, start, abort;
  logic [KW-1:0] k_len;
  logic [AW-1:0] in_base, wt_base, stride, out_addr;
  logic [1:0]    mode_in;
  logic          busy, done, err;
  logic [AW-1:0] sa_input_addr, sa_weight_addr;
  logic          sa_input_first, sa_weight_first, sa_input_last, sa_weight_last;
  logic [1:0]    precision_mode;
  logic          compute_enable, acc_clear, drain_enable, ppu_capture_en;
  logic [IW-1:0] ppu_cycle_idx;
  logic          ub_wr_en;
  logic [AW-1:0] ub_wr_addr;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  ub_stream_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_len(k_len),
    .in_base(in_base), .wt_base(wt_base), .stride(stride), .out_addr(out_addr),
    .mode_in(mode_in), .busy(busy), .done(done), .err(err),
    .sa_input_addr(sa_input_addr), .sa_weight_addr(sa_weight_addr),
    .sa_input_first(sa_input_first), .sa_weight_first(sa_weight_first),
    .sa_input_last(sa_input_last), .sa_weight_last(sa_weight_last),
    .precision_mode(precision_mode), .compute_enable(compute_enable),
    .acc_clear(acc_clear), .drain_enable(drain_enable),
    .ppu_capture_en(ppu_capture_en), .ppu_cycle_idx(ppu_cycle_idx),
    .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr)
`ifdef SEQ_PERF_CNT_EN
    ,.perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: job position as a cycle index since accept (1 = clear cycle).
  bit            m_active;
  int            m_cyc;
  int            m_k;
  logic [AW-1:0] m_in, m_wt, m_stride, m_out, m_in_addr, m_wt_addr;
  logic [1:0]    m_mode;
  bit            m_err;
  logic [31:0]   m_perf;

  // Observation tallies for the directed scenarios.
  int obs_ce, obs_dr, obs_wr, obs_done, obs_ticks, obs_done_at;
  logic [AW-1:0] obs_first_in, obs_last_in, obs_first_wt, obs_last_wt, obs_wr_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int total_cycles(input int k);
    return 1 + k + F + N + 1 + 1;
  endfunction

  function automatic logic [AW-1:0] row_addr(input logic [AW-1:0] base, input int r,
                                             input logic [AW-1:0] step);
    logic [31:0] t;
    t = 32'(base) + 32'(r) * 32'(step);
    return t[AW-1:0];
  endfunction

  task automatic clr_obs();
    obs_ce = 0; obs_dr = 0; obs_wr = 0; obs_done = 0; obs_ticks = 0; obs_done_at = 0;
    obs_first_in = '0; obs_last_in = '0; obs_first_wt = '0; obs_last_wt = '0; obs_wr_addr = '0;
  endtask

  // One clock: advance the model with the current inputs, then compare all outputs.
  task automatic tick();
    bit st, fl, dr, wr, dn;
    int c, k;
    m_err = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_cyc = 0; m_in_addr = '0; m_wt_addr = '0; m_mode = '0; m_perf = '0;
    end else if (m_active) begin
      if (abort) m_active = 1'b0;
      else begin
        m_cyc++;
        if (m_cyc > total_cycles(m_k)) m_active = 1'b0;
        else if (m_cyc == total_cycles(m_k)) m_perf = 32'(m_cyc);
      end
    end else if (start && !abort) begin
      if (k_len == '0) m_err = 1'b1;
      else begin
        m_active = 1'b1; m_cyc = 1; m_k = int'(k_len);
        m_in = in_base; m_wt = wt_base; m_stride = stride; m_out = out_addr; m_mode = mode_in;
      end
    end
    c  = m_cyc;
    k  = m_k;
    st = m_active && c >= 2 && c <= k + 1;
    fl = m_active && c >= k + 2 && c <= k + 1 + int'(F);
    dr = m_active && c >= k + 2 + int'(F) && c <= k + 1 + int'(F) + int'(N);
    wr = m_active && c == k + 2 + int'(F) + int'(N);
    dn = m_active && c == total_cycles(k);
    if (st) begin
      m_in_addr = row_addr(m_in, c - 2, m_stride);
      m_wt_addr = row_addr(m_wt, c - 2, m_stride);
    end

    @(posedge clk);
    #1;
    check("busy",      32'(busy),           32'(m_active));
    check("done",      32'(done),           32'(dn));
    check("err",       32'(err),            32'(m_err));
    check("acc_clear", 32'(acc_clear),      32'(m_active && c == 1));
    check("compute",   32'(compute_enable), 32'(st || fl));
    check("drain",     32'(drain_enable),   32'(dr || wr));
    check("capture",   32'(ppu_capture_en), 32'(dr));
    check("ppu_idx",   32'(ppu_cycle_idx),  dr ? 32'(c - (k + 2 + int'(F))) : 32'd0);
    check("wr_en",     32'(ub_wr_en),       32'(wr));
    check("wr_addr",   32'(ub_wr_addr),     wr ? 32'(m_out) : 32'd0);
    check("in_addr",   32'(sa_input_addr),  32'(m_in_addr));
    check("wt_addr",   32'(sa_weight_addr), 32'(m_wt_addr));
    check("in_first",  32'(sa_input_first), 32'(st && c == 2));
    check("wt_first",  32'(sa_weight_first),32'(st && c == 2));
    check("in_last",   32'(sa_input_last),  32'(st && c == k + 1));
    check("wt_last",   32'(sa_weight_last), 32'(st && c == k + 1));
    check("prec",      32'(precision_mode), 32'(m_mode));
`ifdef SEQ_PERF_CNT_EN
    check("perf",      perf_cycles,         m_perf);
`endif
    obs_ticks++;
    obs_ce += int'(compute_enable);
    obs_dr += int'(drain_enable);
    obs_wr += int'(ub_wr_en);
    obs_done += int'(done);
    if (done) obs_done_at = obs_ticks;
    if (ub_wr_en) obs_wr_addr = ub_wr_addr;
    if (sa_input_first) obs_first_in = sa_input_addr;
    if (sa_input_last)  obs_last_in  = sa_input_addr;
    if (sa_weight_first) obs_first_wt = sa_weight_addr;
    if (sa_weight_last)  obs_last_wt  = sa_weight_addr;
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_job(input int k, input logic [AW-1:0] ib, input logic [AW-1:0] wb,
                           input logic [AW-1:0] sd, input logic [AW-1:0] oa, input logic [1:0] md);
    k_len = KW'(k); in_base = ib; wt_base = wb; stride = sd; out_addr = oa; mode_in = md;
    start = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0;
    in_base = '0; wt_base = '0; stride = '0; out_addr = '0; mode_in = '0;
    m_active = 1'b0; m_cyc = 0; m_k = 0; m_in = '0; m_wt = '0; m_stride = '0; m_out = '0;
    m_in_addr = '0; m_wt_addr = '0; m_mode = '0; m_err = 1'b0; m_perf = '0;
    clr_obs();

    // Reset held 3 cycles, then released.
    for (int i = 0; i < 3; i++) begin rst = 1'b1; tick(); end
    run(2);
    check("reset_busy", 32'(busy), 32'd0);

    // Reference job.
    clr_obs();
    start_job(4, 16'h0010, 16'h0100, 16'h0001, 16'h0200, 2'd2);
    run(total_cycles(4) + 1);
    check("job_ce_cycles",   32'(obs_ce),       32'd13);
    check("job_drain_cycles",32'(obs_dr),       32'd5);
    check("job_wr_count",    32'(obs_wr),       32'd1);
    check("job_wr_addr",     32'(obs_wr_addr),  32'h0200);
    check("job_done_cycle",  32'(obs_done_at),  32'd20);
    check("job_first_in",    32'(obs_first_in), 32'h0010);
    check("job_last_in",     32'(obs_last_in),  32'h0013);
    check("job_first_wt",    32'(obs_first_wt), 32'h0100);
    check("job_last_wt",     32'(obs_last_wt),  32'h0103);

    // Single-row job at the top of the address space.
    clr_obs();
    start_job(1, 16'hFFFF, 16'h8000, 16'h0002, 16'h0300, 2'd1);
    tick();
    check("k1_first_last", 32'({sa_input_first, sa_input_last}), 32'h3);
    check("k1_addr",       32'(sa_input_addr), 32'hFFFF);
    run(total_cycles(1));

    // Two rows: second address wraps.
    start_job(2, 16'hFFFF, 16'hFFFE, 16'h0002, 16'h0304, 2'd3);
    run(2);
    check("wrap_in_addr", 32'(sa_input_addr),  32'h0001);
    check("wrap_wt_addr", 32'(sa_weight_addr), 32'h0000);
    run(total_cycles(2));

    // Zero-length start is rejected.
    start_job(0, 16'h1234, 16'h5678, 16'h0001, 16'h0400, 2'd0);
    check("k0_err",  32'(err),  32'd1);
    check("k0_busy", 32'(busy), 32'd0);
    run(2);

    // Abort on the 3rd drain cycle, then a fresh job 2 cycles later.
    start_job(3, 16'h0040, 16'h0080, 16'h0004, 16'h0500, 2'd1);
    for (int i = 0; i < 200 && m_cyc < 3 + 4 + int'(F); i++) tick();
    check("abort_in_drain", 32'(ppu_cycle_idx), 32'd2);
    clr_obs();
    abort = 1'b1;
    tick();
    check("abort_busy",  32'(busy),         32'd0);
    check("abort_drain", 32'(drain_enable), 32'd0);
    tick();
    check("abort_no_wr",   32'(obs_wr),   32'd0);
    check("abort_no_done", 32'(obs_done), 32'd0);
    clr_obs();
    start_job(4, 16'h0010, 16'h0100, 16'h0001, 16'h0200, 2'd2);
    run(total_cycles(4));
    check("restart_done_cycle", 32'(obs_done_at), 32'd20);

    // Start pulsed mid-stream is ignored.
    clr_obs();
    start_job(5, 16'h1000, 16'h2000, 16'h0010, 16'h0600, 2'd0);
    tick();
    start_job(2, 16'h7777, 16'h8888, 16'h0001, 16'h0700, 2'd3);
    run(total_cycles(5) + 2);
    check("ignore_last_in", 32'(obs_last_in), 32'h1040);
    check("ignore_wr_addr", 32'(obs_wr_addr), 32'h0600);
    check("ignore_done_cnt",32'(obs_done),    32'd1);

    // Start and abort together in idle: abort wins.
    k_len = 8'd3; start = 1'b1; abort = 1'b1;
    tick();
    check("start_abort_idle", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      k_len    = KW'($urandom_range(0, 6));
      in_base  = AW'($urandom);
      wt_base  = AW'($urandom);
      stride   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 8));
      out_addr = AW'($urandom);
      mode_in  = 2'($urandom);
      start    = ($urandom_range(0, 99) < (m_active ? 5 : 30));
      abort    = ($urandom_range(0, 99) < 2);
      rst      = ($urandom_range(0, 999) < 3);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
